// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-port memory arbiter.
// Fetches return one 32-bit word selected from a 64-bit memory line.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    typedef enum logic {
        ACC_RD = 1'b0,
        ACC_WR = 1'b1
    } acc_t;

    // Instruction word select: address bit 2 picks the upper half of the line.
    function automatic logic [31:0] fetch_word(input logic hi, input logic [63:0] line);
        fetch_word = hi ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Priority grant (store > load > fetch) with a starvation counter that
// forces a fetch grant after STARVE_MAX consecutive data grants.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   issue_en,
    input  logic   if_req,
    input  logic   dm_rd_req,
    input  logic   dm_wr_req,
    output logic   gnt_valid,
    output owner_t gnt_owner,
    output acc_t   gnt_acc
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;
    logic          fetch_forced_s;

    // Arbitration; a simultaneous load and store is treated as a store.
    always_comb begin
        fetch_forced_s = if_req && (starve_q == CW'(STARVE_MAX));
        gnt_valid      = 1'b0;
        gnt_owner      = OWN_FETCH;
        gnt_acc        = ACC_RD;
        if (fetch_forced_s) begin
            gnt_valid = 1'b1;
        end else if (dm_wr_req) begin
            gnt_valid = 1'b1;
            gnt_owner = OWN_DATA;
            gnt_acc   = ACC_WR;
        end else if (dm_rd_req) begin
            gnt_valid = 1'b1;
            gnt_owner = OWN_DATA;
        end else if (if_req) begin
            gnt_valid = 1'b1;
        end else begin
            gnt_valid = 1'b0;
        end
    end

    // Count data grants taken while fetch waits; any idle fetch clears it.
    always_comb begin
        starve_d = starve_q;
        if (!if_req) begin
            starve_d = '0;
        end else if (issue_en && gnt_valid) begin
            if (gnt_owner == OWN_DATA) begin
                starve_d = (starve_q == CW'(STARVE_MAX)) ? starve_q : starve_q + CW'(1);
            end else begin
                starve_d = '0;
            end
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: issues the winning access from IDLE, waits
// MEM_LAT cycles for reads, then pulses the owner's ack from DONE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N          = 64,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    output logic [31:0]  if_rdata,
    output logic         if_ack,
    input  logic         dm_rd_req,
    input  logic         dm_wr_req,
    input  logic [N-1:0] dm_addr,
    input  logic [N-1:0] dm_wdata,
    output logic [N-1:0] dm_rdata,
    output logic         dm_ack,
    output logic         mem_re,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
);

    localparam int unsigned LW = $clog2(MEM_LAT + 1);

    state_t         state_q, state_d;
    logic [LW-1:0]  lat_q, lat_d;
    owner_t         owner_q, owner_d;
    acc_t           acc_q, acc_d;
    logic           sel_q, sel_d;
    logic [31:0]    if_rdata_q, if_rdata_d;
    logic [N-1:0]   dm_rdata_q, dm_rdata_d;
    logic           if_ack_q, if_ack_d;
    logic           dm_ack_q, dm_ack_d;

    logic           issue_en_s;
    logic           issue_s;
    logic           gnt_valid_s;
    owner_t         gnt_owner_s;
    acc_t           gnt_acc_s;
    logic           unused_s;

    assign unused_s   = ^if_addr[1:0];
    assign issue_en_s = (state_q == IDLE) && !reset;
    assign issue_s    = issue_en_s && gnt_valid_s;

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk       (clk),
        .reset     (reset),
        .issue_en  (issue_en_s),
        .if_req    (if_req),
        .dm_rd_req (dm_rd_req),
        .dm_wr_req (dm_wr_req),
        .gnt_valid (gnt_valid_s),
        .gnt_owner (gnt_owner_s),
        .gnt_acc   (gnt_acc_s)
    );

    // Memory port is driven only in the issue cycle; fetches are line aligned.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue_s) begin
            mem_re    = (gnt_acc_s == ACC_RD);
            mem_we    = (gnt_acc_s == ACC_WR);
            mem_wdata = dm_wdata;
            if (gnt_owner_s == OWN_DATA) begin
                mem_addr = dm_addr;
            end else begin
                mem_addr = {if_addr[N-1:3], 3'b000};
            end
        end else begin
            mem_re = 1'b0;
        end
    end

    // Sequencer next state: latch owner/type at issue, capture read data at count 1.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        owner_d    = owner_q;
        acc_d      = acc_q;
        sel_d      = sel_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid_s) begin
                    owner_d = gnt_owner_s;
                    acc_d   = gnt_acc_s;
                    sel_d   = if_addr[2];
                    if (gnt_acc_s == ACC_WR) begin
                        state_d  = DONE;
                        dm_ack_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        lat_d   = LW'(MEM_LAT);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (lat_q == LW'(1)) begin
                    state_d = DONE;
                    if (owner_q == OWN_FETCH) begin
                        if_rdata_d = fetch_word(sel_q, mem_rdata[63:0]);
                        if_ack_d   = 1'b1;
                    end else begin
                        dm_rdata_d = mem_rdata;
                        dm_ack_d   = 1'b1;
                    end
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            owner_q    <= OWN_FETCH;
            acc_q      <= ACC_RD;
            sel_q      <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            owner_q    <= owner_d;
            acc_q      <= acc_d;
            sel_q      <= sel_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
        end
    end

    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign if_ack   = if_ack_q;
    assign dm_ack   = dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of requesters, arbitration and memory.
module tb_mem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = 64'd0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_rd_req = 1'b0;
    logic        dm_wr_req = 1'b0;
    logic [63:0] dm_addr = 64'd0;
    logic [63:0] dm_wdata = 64'd0;
    logic [63:0] dm_rdata;
    logic        dm_ack;
    logic        mem_re;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'd0;

    mem_arbiter #(.N(64), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_rd_req(dm_rd_req), .dm_wr_req(dm_wr_req), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] mem [0:63];

    bit          f_active = 0, d_active = 0, d_wr = 0, d_rd = 0;
    logic [63:0] f_addr = 64'd0, d_addr = 64'd0, d_wdata = 64'd0;
    bit          rand_en = 0, auto_data = 0;

    bit          busy = 0, own_data = 0, is_wr = 0, rd_pend = 0;
    int          ack_cyc = 0, rd_due = 0, rd_idx = 0, starve = 0;
    logic [63:0] exp_val = 64'd0;
    logic [31:0] exp_if_rdata = 32'd0;
    logic [63:0] exp_dm_rdata = 64'd0;

    int          last_issue_cyc = 0, last_ack_cyc = 0, data_ack_cyc = 0;
    int          re_cnt = 0, we_cnt = 0, ifack_cnt = 0, dmack_cnt = 0;
    logic [63:0] issue_addr_obs = 64'd0;
    bit          ack_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick(input bit rst);
        @(posedge clk);
        #1;
        cyc++;
        reset = rst;
        mem_rdata = (rd_pend && cyc == rd_due) ? mem[rd_idx] : {$urandom, $urandom};
        if (rand_en && !f_active && $urandom_range(0, 2) == 0) begin
            f_active = 1;
            f_addr   = 64'($urandom_range(0, 511));
        end
        if ((rand_en && !d_active && $urandom_range(0, 1) == 0) || (auto_data && !d_active)) begin
            int kind;
            kind     = auto_data ? 0 : int'($urandom_range(0, 3));
            d_active = 1;
            d_rd     = (kind != 2);
            d_wr     = (kind >= 2);
            d_addr   = {55'd0, 6'($urandom_range(0, 63)), 3'b000};
            d_wdata  = {$urandom, $urandom};
        end
        if_req    = f_active;
        if_addr   = f_active ? f_addr : {$urandom, $urandom};
        dm_rd_req = d_active && d_rd;
        dm_wr_req = d_active && d_wr;
        dm_addr   = d_active ? d_addr : {$urandom, $urandom};
        dm_wdata  = d_active ? d_wdata : {$urandom, $urandom};
    endtask

    task automatic observe();
        bit exp_if_ack, exp_dm_ack, exp_issue, win_data, win_wr;
        logic [63:0] win_addr;
        #3;
        if (mem_re | mem_we) begin
            last_issue_cyc = cyc;
            issue_addr_obs = mem_addr;
            re_cnt += int'(mem_re);
            we_cnt += int'(mem_we);
        end
        if (if_ack | dm_ack) begin
            last_ack_cyc = cyc;
            ack_log.push_back(dm_ack);
            if (dm_ack) data_ack_cyc = cyc;
            ifack_cnt += int'(if_ack);
            dmack_cnt += int'(dm_ack);
        end
        if (reset) begin
            chk("rst_mem_re", mem_re, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_if_ack", if_ack, 0);
            chk("rst_dm_ack", dm_ack, 0);
            busy = 0; rd_pend = 0; starve = 0;
            exp_if_rdata = 32'd0; exp_dm_rdata = 64'd0;
            return;
        end
        if (rd_pend && cyc == rd_due) rd_pend = 0;

        exp_if_ack = busy && cyc == ack_cyc && !own_data;
        exp_dm_ack = busy && cyc == ack_cyc && own_data;
        chk("if_ack", if_ack, exp_if_ack);
        chk("dm_ack", dm_ack, exp_dm_ack);
        if (exp_if_ack) exp_if_rdata = f_addr[2] ? exp_val[63:32] : exp_val[31:0];
        if (exp_dm_ack && !is_wr) exp_dm_rdata = exp_val;
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("dm_rdata", dm_rdata, exp_dm_rdata);

        exp_issue = !busy && (f_active || d_active);
        chk("issue", mem_re | mem_we, exp_issue);
        if (exp_issue) begin
            win_data = d_active && !(f_active && starve == STARVE_MAX);
            win_wr   = win_data && d_wr;
            win_addr = win_data ? d_addr : {f_addr[63:3], 3'b000};
            chk("mem_re", mem_re, !win_wr);
            chk("mem_we", mem_we, win_wr);
            chk("mem_addr", mem_addr, win_addr);
            busy     = 1;
            own_data = win_data;
            is_wr    = win_wr;
            exp_val  = mem[win_addr[8:3]];
            if (win_wr) begin
                chk("mem_wdata", mem_wdata, d_wdata);
                mem[win_addr[8:3]] = d_wdata;
                ack_cyc = cyc + 1;
            end else begin
                rd_pend = 1;
                rd_due  = cyc + MEM_LAT;
                rd_idx  = int'(win_addr[8:3]);
                ack_cyc = cyc + MEM_LAT + 1;
            end
        end else begin
            chk("idle_addr", mem_addr, 0);
            chk("idle_wdata", mem_wdata, 0);
        end
        if (!f_active) starve = 0;
        else if (exp_issue) starve = win_data ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;

        if (exp_if_ack) begin busy = 0; f_active = 0; end
        if (exp_dm_ack) begin busy = 0; d_active = 0; end
    endtask

    task automatic one_cycle(input bit rst);
        tick(rst);
        observe();
    endtask

    task automatic run_quiet(input int maxc);
        int n = 0;
        while ((f_active || d_active || busy) && n < maxc) begin
            one_cycle(0);
            n++;
        end
        chk("timeout", 64'(f_active || d_active || busy), 0);
    endtask

    initial begin
        logic [5:0] pat;
        int n;
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};

        // Reset with requests pending: no strobes, no acks.
        f_active = 1; f_addr = 64'h1F0;
        d_active = 1; d_wr = 1; d_rd = 0; d_addr = 64'h10; d_wdata = 64'h55;
        repeat (3) one_cycle(1);
        f_active = 0; d_active = 0;
        repeat (2) one_cycle(0);
        chk("reset_if_rdata", if_rdata, 0);
        chk("reset_dm_rdata", dm_rdata, 0);

        // Fetch only, upper word of line 0x100.
        mem[32] = 64'hAAAA_BBBB_CCCC_DDDD;
        f_active = 1; f_addr = 64'h104;
        run_quiet(20);
        chk("fetch_addr", issue_addr_obs, 64'h100);
        chk("fetch_lat", 64'(last_ack_cyc - last_issue_cyc), 64'd3);
        chk("fetch_word", if_rdata, 32'hAAAABBBB);

        // Store then load of the same address.
        d_active = 1; d_wr = 1; d_rd = 0; d_addr = 64'h40; d_wdata = 64'h1234;
        run_quiet(20);
        chk("store_lat", 64'(last_ack_cyc - last_issue_cyc), 64'd1);
        d_active = 1; d_wr = 0; d_rd = 1; d_addr = 64'h40;
        run_quiet(20);
        chk("load_lat", 64'(last_ack_cyc - last_issue_cyc), 64'd3);
        chk("load_data", dm_rdata, 64'h1234);

        // Contention: load before fetch, fetch issues right after dm_ack.
        ack_log.delete();
        f_active = 1; f_addr = 64'h180;
        d_active = 1; d_wr = 0; d_rd = 1; d_addr = 64'h88;
        run_quiet(40);
        chk("contend_order", 64'({ack_log.size() == 2, ack_log[0], ack_log[1]}), 64'b110);
        chk("contend_gap", 64'(last_issue_cyc - data_ack_cyc), 64'd1);

        // Starvation: four data grants, one fetch, then data again.
        ack_log.delete();
        f_active = 1; f_addr = 64'h1C8;
        auto_data = 1;
        n = 0;
        while (ack_log.size() < 6 && n < 200) begin one_cycle(0); n++; end
        auto_data = 0;
        run_quiet(40);
        pat = 6'd0;
        for (int i = 0; i < 6 && i < ack_log.size(); i++) pat[5-i] = ack_log[i];
        chk("starve_pattern", 64'(pat), 64'b111101);

        // Simultaneous load and store: one write, one ack.
        re_cnt = 0; we_cnt = 0; dmack_cnt = 0;
        d_active = 1; d_wr = 1; d_rd = 1; d_addr = 64'h48; d_wdata = 64'hCAFE;
        run_quiet(20);
        chk("rdwr_re", 64'(re_cnt), 0);
        chk("rdwr_we", 64'(we_cnt), 1);
        chk("rdwr_ack", 64'(dmack_cnt), 1);

        // Reset one cycle into a read; fetch reissues right after reset drops.
        ifack_cnt = 0;
        f_active = 1; f_addr = 64'h108;
        one_cycle(0);
        chk("mid_issue", mem_re, 1);
        one_cycle(1);
        one_cycle(0);
        chk("post_rst_issue", mem_re, 1);
        run_quiet(20);
        chk("post_rst_acks", 64'(ifack_cnt), 1);

        // Random traffic.
        rand_en = 1;
        repeat (2000) one_cycle(0);
        rand_en = 0;
        run_quiet(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
